// File: rtl/hs_send_gen.sv
// ---------------------------------------------------------------------------
// hs_send_gen
//
// Clocked transmitter for a self-timed peripheral handshake. A single start
// request emits a burst of num_tokens tokens with incrementing data. Each
// token takes four steps:
//   1. SETUP: data is presented for one cycle.
//   2. PULSE: Send_out is driven low for PULSE_W cycles.
//   3. WAIT:  the block waits for a falling edge on the receiver's
//             active-low Ack_in.
//   4. The next token starts, or FIN is entered after the last token.
// A timeout ends the burst if the receiver stalls.
//
// Ports:
//   CLK          in   system clock, rising edge
//   RST          in   asynchronous active-low reset
//   start        in   one-cycle burst request (sampled only in IDLE)
//   num_tokens   in   tokens in the burst (sampled with start)
//   data_base    in   first token value (sampled with start)
//   Ack_in       in   active-low acknowledge, asynchronous to CLK
//   Send_out     out  active-low send strobe
//   data_out     out  token data, stable from SETUP through WAIT
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse at burst end (normal or timeout)
//   timeout_err  out  sticky timeout flag, cleared by the next accepted start
//   sent_cnt     out  tokens acknowledged in the current/last burst
// ---------------------------------------------------------------------------
module hs_send_gen #(
    parameter int DW      = 8,
    parameter int PULSE_W = 1,
    parameter int TIMEOUT = 255,
    parameter int CNTW    = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic [CNTW-1:0] num_tokens,
    input  logic [DW-1:0]   data_base,
    input  logic            Ack_in,
    output logic            Send_out,
    output logic [DW-1:0]   data_out,
    output logic            busy,
    output logic            done,
    output logic            timeout_err,
    output logic [CNTW-1:0] sent_cnt
);

    localparam int PW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(PULSE_W - 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_WAIT,
        S_FIN
    } state_t;

    state_t          r_state;
    logic            r_ack_s1;
    logic            r_ack_s2;
    logic            r_ack_prev;
    logic            r_ack_seen;
    logic [CNTW-1:0] r_num;
    logic [PW-1:0]   r_pcnt;
    logic [TW-1:0]   r_tcnt;
    logic            r_send;
    logic [DW-1:0]   r_data;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [CNTW-1:0] r_sent;

    logic            w_ack_fall;
    logic            w_ack;
    logic [CNTW-1:0] w_sent_next;

    // Falling edge of the synchronised acknowledge.
    assign w_ack_fall  = r_ack_prev & ~r_ack_s2;
    // An acknowledge caught during the pulse, or one arriving now, completes
    // the token. Several falls within one token therefore count only once.
    assign w_ack       = r_ack_seen | w_ack_fall;
    assign w_sent_next = r_sent + 1'b1;

    // NOTE: state is updated with non-blocking assignments so that every
    // register samples pre-edge values, whatever the statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            // Synchroniser flops reset to the idle (high) level of Ack_in,
            // so that releasing reset cannot look like an acknowledge.
            r_ack_s1   <= 1'b1;
            r_ack_s2   <= 1'b1;
            r_ack_prev <= 1'b1;
            r_ack_seen <= 1'b0;
            r_num      <= '0;
            r_pcnt     <= '0;
            r_tcnt     <= '0;
            r_send     <= 1'b1;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_sent     <= '0;
        end else begin
            r_ack_s1   <= Ack_in;
            r_ack_s2   <= r_ack_s1;
            r_ack_prev <= r_ack_s2;
            r_done     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num  <= num_tokens;
                        r_sent <= '0;
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        if (num_tokens == '0) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_data  <= data_base;
                            r_state <= S_SETUP;
                        end
                    end
                end

                S_SETUP: begin
                    // A fall seen here is stale and must not count for this token.
                    r_send     <= 1'b0;
                    r_pcnt     <= '0;
                    r_ack_seen <= 1'b0;
                    r_state    <= S_PULSE;
                end

                S_PULSE: begin
                    if (w_ack_fall) begin
                        r_ack_seen <= 1'b1;
                    end
                    if (r_pcnt == PCNT_LAST) begin
                        r_send  <= 1'b1;
                        r_tcnt  <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_pcnt <= r_pcnt + 1'b1;
                    end
                end

                S_WAIT: begin
                    if (w_ack) begin
                        r_sent <= w_sent_next;
                        if (w_sent_next == r_num) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_data  <= r_data + 1'b1;
                            r_state <= S_SETUP;
                        end
                    end else if (r_tcnt == TCNT_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end

                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_send  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Send_out    = r_send;
    assign data_out    = r_data;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout_err = r_err;
    assign sent_cnt    = r_sent;

endmodule
